// File: rtl/gb_lcd_capture_if.sv
// Game Boy LCD capture bus: pixel input side and framebuffer write side.
// The capture block is the master; the source/RAM harness is the slave.
interface gb_lcd_capture_if #(
  parameter int ADDR_W = 15
);
  logic              lcd_frame_start;
  logic              lcd_pix_valid;
  logic [1:0]        lcd_pix;
  logic              fb_wr_ready;
  logic              fb_we;
  logic [ADDR_W:0]   fb_waddr;
  logic [1:0]        fb_wdata;
  logic              fb_disp_bank;
  logic              frame_done;
  logic              overflow;
  logic              short_frame;

  modport master (
    input  lcd_frame_start, lcd_pix_valid, lcd_pix, fb_wr_ready,
    output fb_we, fb_waddr, fb_wdata, fb_disp_bank,
    output frame_done, overflow, short_frame
  );

  modport slave (
    output lcd_frame_start, lcd_pix_valid, lcd_pix, fb_wr_ready,
    input  fb_we, fb_waddr, fb_wdata, fb_disp_bank,
    input  frame_done, overflow, short_frame
  );
endinterface

// File: rtl/gb_lcd_capture.sv
// Game Boy LCD pixel capture into a double-buffered framebuffer.
// Linear pixel counter feeds a show-ahead FIFO with a registered head.
module gb_lcd_capture #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 144,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 15
) (
  input  logic               fbclk,
  input  logic               fbclk_rst,
  gb_lcd_capture_if.master   bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic              last;
    logic              bank;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        pix;
  } ent_t;

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] cur_cnt;
  logic              wr_bank;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  ent_t              din;
  ent_t              head;
  ent_t              mem [FIFO_DEPTH];

  always_comb begin
    cur_cnt   = bus.lcd_frame_start ? '0 : pix_cnt;
    push      = bus.lcd_pix_valid &
                (bus.lcd_frame_start | (state == CAPTURE));
    push_ok   = push & (count != FULL);
    pop       = bus.fb_we & bus.fb_wr_ready;
    count_nxt = count + CW'(push_ok) - CW'(pop);
    din       = '0;
    din.last  = (cur_cnt == LAST_IDX);
    din.bank  = wr_bank;
    din.idx   = cur_cnt;
    din.pix   = bus.lcd_pix;
  end

  // Dropped pixels still advance the counter so geometry stays intact.
  always_ff @(posedge fbclk) begin
    if (fbclk_rst) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      wr_bank         <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.short_frame <= 1'b0;
    end else begin
      if (state == CAPTURE && bus.lcd_frame_start && pix_cnt != '0)
        bus.short_frame <= 1'b1;
      if (push && count == FULL)
        bus.overflow <= 1'b1;
      if (push) begin
        if (din.last) begin
          state   <= IDLE;
          pix_cnt <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          state   <= CAPTURE;
          pix_cnt <= cur_cnt + 1'b1;
        end
      end else if (bus.lcd_frame_start) begin
        state   <= CAPTURE;
        pix_cnt <= '0;
      end
    end
  end

  always_ff @(posedge fbclk) begin
    if (push_ok)
      mem[wptr] <= din;
  end

  // Head mirrors mem[rptr]; a push into an empty or draining FIFO bypasses.
  always_ff @(posedge fbclk) begin
    if (fbclk_rst) begin
      wptr             <= '0;
      rptr             <= '0;
      count            <= '0;
      head             <= '0;
      bus.fb_we        <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.fb_disp_bank <= 1'b1;
    end else begin
      bus.frame_done <= pop & head.last;
      if (pop && head.last)
        bus.fb_disp_bank <= head.bank;
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      count     <= count_nxt;
      bus.fb_we <= (count_nxt != '0);
      if (pop) begin
        if (count > CW'(1))
          head <= mem[rptr + 1'b1];
        else if (push_ok)
          head <= din;
      end else if (count == '0 && push_ok) begin
        head <= din;
      end
    end
  end

  assign bus.fb_waddr = {head.bank, head.idx};
  assign bus.fb_wdata = head.pix;
endmodule
